imm_encode: RTL and testbench
=============================

Name: imm_encode

Overview:
- Streaming RV32I immediate encoder. It scatters a 32-bit immediate value into the instruction bit positions selected by the immediate format, merging it with a template instruction that carries the non-immediate fields.
- It is the inverse of the immediate-extend stage: the extender gathers instruction bits into a value, this block places a value into instruction bits.
- It sits between the test/boot loader stream and the instruction-memory write port. It produces a counted burst of encoded words with auto-incrementing byte addresses and per-word range checking.

Parameters:
- DATAWIDTH, 32, instruction and immediate width.
- ADDRWIDTH, 10, byte-address width of the instruction-memory write port.
- ERRCNTWIDTH, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- start_i  in  1  begin a burst; honoured only in IDLE.
- BaseAddr_i  in  ADDRWIDTH  first write address of the burst, captured on start.
- Len_i  in  16  number of words in the burst, captured on start.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  input word accepted when valid and ready are both high.
- ImmSrc_i  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J.
- Imm_i  in  DATAWIDTH  immediate value to encode.
- Instr_i  in  DATAWIDTH  template instruction; its immediate bits are ignored.
- out_valid_o  out  1  encoded word valid.
- out_ready_i  in  1  downstream accepts the word.
- Instr_o  out  DATAWIDTH  encoded instruction.
- Addr_o  out  ADDRWIDTH  byte address for Instr_o.
- Err_o  out  1  range, alignment or format error on Instr_o.
- ErrCount_o  out  ERRCNTWIDTH  errored words in the current burst, saturating.
- Done_o  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: state IDLE; out_valid_o, Instr_o, Addr_o, Err_o, ErrCount_o and Done_o all 0. An in-flight word is discarded.
- Encoding: every bit not listed below is copied from Instr_i.
  - I: Instr_o[31:20]=Imm[11:0].
  - S: Instr_o[31:25]=Imm[11:5], Instr_o[11:7]=Imm[4:0].
  - B: Instr_o[31]=Imm[12], Instr_o[7]=Imm[11], Instr_o[30:25]=Imm[10:5], Instr_o[11:8]=Imm[4:1].
  - U: Instr_o[31:12]=Imm[31:12].
  - J: Instr_o[31]=Imm[20], Instr_o[30:21]=Imm[10:1], Instr_o[20]=Imm[11], Instr_o[19:12]=Imm[19:12].
- Error conditions (Err=1):
  - I/S: Imm[31:11] are not all equal (value outside signed 12-bit).
  - B: Imm[31:12] are not all equal, or Imm[0]=1.
  - J: Imm[31:20] are not all equal, or Imm[0]=1.
  - U: Imm[11:0] is not zero.
  - ImmSrc 101-111: Err=1 and Instr_o=Instr_i unchanged.
  - An errored word is still encoded, with out-of-range bits truncated.
- FSM states: IDLE, RUN, DRAIN (plus HALT with the optional feature).
- IDLE:
  - in_ready_o=0.
  - start_i with Len_i!=0: capture Len into a remaining counter, load the address counter with BaseAddr_i, clear ErrCount_o, go to RUN.
  - start_i with Len_i=0: Done_o pulses next cycle; stay in IDLE.
- RUN:
  - in_ready_o = (!out_valid_o || out_ready_i).
  - Accepted word: on the next cycle out_valid_o=1 with Instr_o, Err_o and Addr_o=address counter.
  - Address counter += 4, wrapping modulo 2^ADDRWIDTH. Remaining counter -= 1.
  - ErrCount_o += Err, saturating at all-ones.
  - When remaining reaches 0 on an accept, go to DRAIN.
- Latency and handshake:
  - Latency is 1 cycle from accept to out_valid_o.
  - Outputs hold stable while out_valid_o && !out_ready_i.
  - An output handshake and a new accept in the same cycle give back-to-back words with no bubble.
  - After a handshake with no new accept, out_valid_o=0.
- DRAIN: in_ready_o=0. On the final output handshake: go to IDLE and pulse Done_o on the next cycle.
- start_i is ignored in RUN, DRAIN and HALT.
- Throughput is 1 word per cycle with out_ready_i held high.

Optional Feature:
- Macro: IMM_ENCODE_STRICT_EN.
- Defined:
  - An accepted errored word is still presented on the output with Err_o=1.
  - After that output handshake, the FSM enters HALT instead of continuing: in_ready_o=0, Done_o is not pulsed, and ErrCount_o is held.
  - HALT exits only via start_i, which is handled as in IDLE, or via reset.
- Undefined: errors are flagged per word only, and the burst always runs to completion.

Test Plan:
- I-type: Instr_i=0x00000013, Imm=0xFFFFFFFF, ImmSrc=000 -> Instr_o=0xFFF00013, Err_o=0. Then Imm=0x00000800 -> Err_o=1, ErrCount_o=1.
- B-type: Instr_i=0x00000063, Imm=0x00000010, ImmSrc=010 -> Instr_o=0x00000863, Err_o=0. Then Imm=0x00000011 -> Err_o=1.
- J and U:
  - Instr_i=0x0000006F, Imm=0xFFFFFFFE, ImmSrc=100 -> Instr_o=0xFFFFF06F.
  - Instr_i=0x000000B7, Imm=0x12345000, ImmSrc=011 -> Instr_o=0x123450B7, Err_o=0.
  - Imm=0x12345001 -> Err_o=1.
- Burst, backpressure and wrap:
  - Stimulus: BaseAddr=0x3FC, Len=3; out_ready_i held low for 2 cycles on the first word.
  - Instr_o and Addr_o stay stable and in_ready_o=0 during the stall.
  - Addresses are 0x3FC, 0x000, 0x004.
  - Done_o is high for exactly one cycle after the 3rd handshake; the FSM returns to IDLE.
- Corner cases:
  - Len_i=0 -> Done_o pulses with no output.
  - rst_n_i low mid-burst -> next cycle out_valid_o=0, ErrCount_o=0, FSM in IDLE.
  - start_i while in RUN -> no effect.
- Strict mode (IMM_ENCODE_STRICT_EN defined):
  - Stimulus: Len=4, 2nd word ImmSrc=111.
  - 2nd word is output with Err_o=1, FSM enters HALT, in_ready_o stays 0, no Done_o.
  - start_i with Len=1 restarts the burst.

Source files
------------

// File: rtl/imm_encode.sv
// imm_encode: streaming RV32I immediate encoder with a counted burst.
// Scatters a 32-bit immediate into the instruction bit positions of the
// selected format (I/S/B/U/J), merges it with a template instruction and
// emits the result with an auto-incrementing byte address, a per-word
// range/alignment/format error flag and a saturating error counter.
//
// Optional build macro: IMM_ENCODE_STRICT_EN
//   When defined, the first errored word stops the burst after it has been
//   handed downstream (state HALT); only start_i or reset leave HALT.
//
// state | meaning
// IDLE  | waiting for start_i, in_ready_o low
// RUN   | accepting words until the remaining count runs out
// DRAIN | all words accepted, waiting for the last output handshake
// HALT  | (strict build only) stopped after an errored word

module imm_encode #(
    parameter int DATAWIDTH   = 32,
    parameter int ADDRWIDTH   = 10,
    parameter int ERRCNTWIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [ADDRWIDTH-1:0]   BaseAddr_i,
    input  logic [15:0]            Len_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [2:0]             ImmSrc_i,
    input  logic [DATAWIDTH-1:0]   Imm_i,
    input  logic [DATAWIDTH-1:0]   Instr_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATAWIDTH-1:0]   Instr_o,
    output logic [ADDRWIDTH-1:0]   Addr_o,
    output logic                   Err_o,
    output logic [ERRCNTWIDTH-1:0] ErrCount_o,
    output logic                   Done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
`ifdef IMM_ENCODE_STRICT_EN
        , HALT = 2'd3
`endif
    } state_t;

    state_t                 state;
    logic [15:0]            remaining;
    logic [ADDRWIDTH-1:0]   addr_cnt;
    logic [DATAWIDTH-1:0]   enc_instr;
    logic                   enc_err;
    logic                   accept;
    logic                   out_hs;

    // Scatter the immediate into the selected format and flag values that
    // the format cannot represent; the word is still built from truncated bits.
    always_comb begin
        enc_instr = Instr_i;
        enc_err   = 1'b0;
        case (ImmSrc_i)
            3'b000: begin
                enc_instr = {Imm_i[11:0], Instr_i[19:0]};
                enc_err   = !((&Imm_i[31:11]) || !(|Imm_i[31:11]));
            end
            3'b001: begin
                enc_instr = {Imm_i[11:5], Instr_i[24:12], Imm_i[4:0], Instr_i[6:0]};
                enc_err   = !((&Imm_i[31:11]) || !(|Imm_i[31:11]));
            end
            3'b010: begin
                enc_instr = {Imm_i[12], Imm_i[10:5], Instr_i[24:12],
                             Imm_i[4:1], Imm_i[11], Instr_i[6:0]};
                enc_err   = !((&Imm_i[31:12]) || !(|Imm_i[31:12])) || Imm_i[0];
            end
            3'b011: begin
                enc_instr = {Imm_i[31:12], Instr_i[11:0]};
                enc_err   = |Imm_i[11:0];
            end
            3'b100: begin
                enc_instr = {Imm_i[20], Imm_i[10:1], Imm_i[11], Imm_i[19:12],
                             Instr_i[11:0]};
                enc_err   = !((&Imm_i[31:20]) || !(|Imm_i[31:20])) || Imm_i[0];
            end
            default: begin
                enc_instr = Instr_i;
                enc_err   = 1'b1;
            end
        endcase
    end

    // Accept only in RUN when the output slot is free or being drained; the
    // strict build refuses to accept past an errored word so HALT is clean.
    always_comb begin
        in_ready_o = 1'b0;
        if (state == RUN) begin
`ifdef IMM_ENCODE_STRICT_EN
            in_ready_o = !out_valid_o || (out_ready_i && !Err_o);
`else
            in_ready_o = !out_valid_o || out_ready_i;
`endif
        end
    end

    assign accept = in_valid_i && in_ready_o;
    assign out_hs = out_valid_o && out_ready_i;

    // Burst FSM with registered output word, address and error bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            remaining   <= '0;
            addr_cnt    <= '0;
            out_valid_o <= 1'b0;
            Instr_o     <= '0;
            Addr_o      <= '0;
            Err_o       <= 1'b0;
            ErrCount_o  <= '0;
            Done_o      <= 1'b0;
        end else begin
            Done_o <= 1'b0;
            case (state)
                RUN: begin
                    if (accept) begin
                        out_valid_o <= 1'b1;
                        Instr_o     <= enc_instr;
                        Err_o       <= enc_err;
                        Addr_o      <= addr_cnt;
                        addr_cnt    <= addr_cnt + ADDRWIDTH'(4);
                        remaining   <= remaining - 16'd1;
                        if (enc_err && (ErrCount_o != '1))
                            ErrCount_o <= ErrCount_o + ERRCNTWIDTH'(1);
                        if (remaining == 16'd1)
                            state <= DRAIN;
                    end else if (out_hs) begin
                        out_valid_o <= 1'b0;
`ifdef IMM_ENCODE_STRICT_EN
                        if (Err_o)
                            state <= HALT;
`endif
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        out_valid_o <= 1'b0;
`ifdef IMM_ENCODE_STRICT_EN
                        if (Err_o) begin
                            state <= HALT;
                        end else begin
                            state  <= IDLE;
                            Done_o <= 1'b1;
                        end
`else
                        state  <= IDLE;
                        Done_o <= 1'b1;
`endif
                    end
                end
                // IDLE and HALT: both wait for a new start
                default: begin
                    if (start_i) begin
                        if (Len_i != 16'd0) begin
                            remaining  <= Len_i;
                            addr_cnt   <= BaseAddr_i;
                            ErrCount_o <= '0;
                            state      <= RUN;
                        end else begin
                            Done_o <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encode.sv
// Directed testbench for imm_encode: format encodings, error flags, burst
// addressing with wrap, backpressure, Done pulse, reset and start corners.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_imm_encode;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [15:0] len;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_src;
    logic [31:0] imm;
    logic [31:0] instr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [9:0]  addr_out;
    logic        err;
    logic [7:0]  err_count;
    logic        done;

    int total = 0;
    int bad   = 0;

    imm_encode #(.DATAWIDTH(32), .ADDRWIDTH(10), .ERRCNTWIDTH(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .BaseAddr_i  (base_addr),
        .Len_i       (len),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ImmSrc_i    (imm_src),
        .Imm_i       (imm),
        .Instr_i     (instr_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .Instr_o     (instr_out),
        .Addr_o      (addr_out),
        .Err_o       (err),
        .ErrCount_o  (err_count),
        .Done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_burst(input logic [9:0] b, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; base_addr = b; len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one word and return at the falling edge after it was accepted.
    task automatic push(input logic [2:0] src, input logic [31:0] v, input logic [31:0] ins);
        int n;
        in_valid = 1'b1; imm_src = src; imm = v; instr_in = ins;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic settle();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        start     = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0;
        imm_src = '0; imm = '0; instr_in = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instr_out); end
        total++; if (addr_out !== 10'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", addr_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", err); end
        total++; if (err_count !== 8'h0) begin bad++; $display("FAIL rst_errcount got=%0d want=0", err_count); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_itype();
        out_ready = 1'b1;
        start_burst(10'h100, 16'd2);
        push(3'b000, 32'hFFFF_FFFF, 32'h0000_0013);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL i_valid got=%0b want=1", out_valid); end
        total++; if (instr_out !== 32'hFFF0_0013) begin bad++; $display("FAIL i_instr got=%h want=fff00013", instr_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL i_err got=%0b want=0", err); end
        total++; if (addr_out !== 10'h100) begin bad++; $display("FAIL i_addr got=%h want=100", addr_out); end
        push(3'b000, 32'h0000_0800, 32'h0000_0013);
        total++; if (instr_out !== 32'h8000_0013) begin bad++; $display("FAIL i_range_instr got=%h want=80000013", instr_out); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL i_range_err got=%0b want=1", err); end
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL i_errcount got=%0d want=1", err_count); end
        total++; if (addr_out !== 10'h104) begin bad++; $display("FAIL i_addr2 got=%h want=104", addr_out); end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL i_done got=%0b want=1", done); end
        settle();
    endtask

    task automatic test_btype_stype();
        out_ready = 1'b1;
        start_burst(10'h000, 16'd3);
        push(3'b010, 32'h0000_0010, 32'h0000_0063);
        total++; if (instr_out !== 32'h0000_0863) begin bad++; $display("FAIL b_instr got=%h want=00000863", instr_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL b_err got=%0b want=0", err); end
        push(3'b010, 32'h0000_0011, 32'h0000_0063);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL b_align_err got=%0b want=1", err); end
        push(3'b001, 32'hFFFF_FFF4, 32'h0000_0023);
        total++; if (instr_out !== 32'hFE00_0A23) begin bad++; $display("FAIL s_instr got=%h want=fe000a23", instr_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL s_err got=%0b want=0", err); end
        settle();
    endtask

    task automatic test_ju();
        out_ready = 1'b1;
        start_burst(10'h000, 16'd3);
        push(3'b100, 32'hFFFF_FFFE, 32'h0000_006F);
        total++; if (instr_out !== 32'hFFFF_F06F) begin bad++; $display("FAIL j_instr got=%h want=fffff06f", instr_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL j_err got=%0b want=0", err); end
        push(3'b011, 32'h1234_5000, 32'h0000_00B7);
        total++; if (instr_out !== 32'h1234_50B7) begin bad++; $display("FAIL u_instr got=%h want=123450b7", instr_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL u_err got=%0b want=0", err); end
        push(3'b011, 32'h1234_5001, 32'h0000_00B7);
        total++; if (instr_out !== 32'h1234_50B7) begin bad++; $display("FAIL u_trunc_instr got=%h want=123450b7", instr_out); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL u_err2 got=%0b want=1", err); end
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL ju_errcount got=%0d want=1", err_count); end
        settle();
    endtask

    task automatic test_burst_backpressure();
        out_ready = 1'b0;
        start_burst(10'h3FC, 16'd3);
        push(3'b000, 32'd1, 32'h0000_0013);
        total++; if (addr_out !== 10'h3FC) begin bad++; $display("FAIL bp_addr0 got=%h want=3fc", addr_out); end
        total++; if (instr_out !== 32'h0010_0013) begin bad++; $display("FAIL bp_instr0 got=%h want=00100013", instr_out); end
        in_valid = 1'b1; imm_src = 3'b000; imm = 32'd2; instr_in = 32'h0000_0013;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_stall1 got=%0b want=0", in_ready); end
        @(negedge clk);
        total++; if (instr_out !== 32'h0010_0013 || addr_out !== 10'h3FC || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_hold instr=%h addr=%h valid=%0b want 00100013/3fc/1", instr_out, addr_out, out_valid);
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_stall2 got=%0b want=0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (instr_out !== 32'h0020_0013 || addr_out !== 10'h000) begin
            bad++; $display("FAIL bp_word1 instr=%h addr=%h want 00200013/000", instr_out, addr_out);
        end
        imm = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (instr_out !== 32'h0030_0013 || addr_out !== 10'h004) begin
            bad++; $display("FAIL bp_word2 instr=%h addr=%h want 00300013/004", instr_out, addr_out);
        end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL bp_done_early got=%0b want=0", done); end
        @(negedge clk);
        total++; if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_done done=%0b valid=%0b want 1/0", done, out_valid);
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_idle_ready got=%0b want=0", in_ready); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL bp_done_width got=%0b want=0", done); end
        settle();
    endtask

    task automatic test_len_zero();
        start_burst(10'h080, 16'd0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL len0_done got=%0b want=1", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL len0_valid got=%0b want=0", out_valid); end
        @(negedge clk);
        total++; if (done !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL len0_after done=%0b ready=%0b want 0/0", done, in_ready);
        end
        settle();
    endtask

    task automatic test_reset_midburst();
        out_ready = 1'b0;
        start_burst(10'h000, 16'd3);
        push(3'b000, 32'h0000_0800, 32'h0000_0013);
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL mr_errcount_pre got=%0d want=1", err_count); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mr_reset valid=%0b errcount=%0d ready=%0b want 0/0/0", out_valid, err_count, in_ready);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        start_burst(10'h010, 16'd1);
        push(3'b000, 32'd5, 32'h0000_0013);
        total++; if (addr_out !== 10'h010 || instr_out !== 32'h0050_0013) begin
            bad++; $display("FAIL mr_restart addr=%h instr=%h want 010/00500013", addr_out, instr_out);
        end
        settle();
    endtask

    task automatic test_start_in_run();
        out_ready = 1'b1;
        start_burst(10'h020, 16'd2);
        push(3'b000, 32'd1, 32'h0000_0013);
        total++; if (addr_out !== 10'h020) begin bad++; $display("FAIL sr_addr0 got=%h want=020", addr_out); end
        start = 1'b1; base_addr = 10'h200; len = 16'd5;
        push(3'b000, 32'd2, 32'h0000_0013);
        start = 1'b0;
        total++; if (addr_out !== 10'h024) begin bad++; $display("FAIL sr_addr1 got=%h want=024", addr_out); end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sr_done got=%0b want=1", done); end
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sr_idle got=%0b want=0", in_ready); end
        settle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        start_burst(10'h040, 16'd4);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                total++;
                if (out_valid !== 1'b1 || instr_out !== ((32'(k) << 20) | 32'h13) ||
                    addr_out !== 10'(10'h040 + 4 * (k - 1))) begin
                    bad++;
                    $display("FAIL b2b_word%0d valid=%0b instr=%h addr=%h want 1/%h/%h", k - 1,
                             out_valid, instr_out, addr_out, (32'(k) << 20) | 32'h13,
                             10'(10'h040 + 4 * (k - 1)));
                end
            end
            if (k < 4) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%0b want=1", k, in_ready); end
                in_valid = 1'b1; imm_src = 3'b000; imm = 32'(k + 1); instr_in = 32'h0000_0013;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_done done=%0b valid=%0b want 1/0", done, out_valid);
        end
        settle();
    endtask

`ifdef IMM_ENCODE_STRICT_EN
    task automatic test_strict();
        out_ready = 1'b1;
        start_burst(10'h000, 16'd4);
        push(3'b000, 32'd1, 32'h0000_0013);
        push(3'b111, 32'd2, 32'h0000_0013);
        total++; if (err !== 1'b1 || instr_out !== 32'h0000_0013 || out_valid !== 1'b1) begin
            bad++; $display("FAIL st_errword err=%0b instr=%h valid=%0b want 1/00000013/1", err, instr_out, out_valid);
        end
        in_valid = 1'b1; imm_src = 3'b000; imm = 32'd3;
        repeat (3) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL st_halt ready=%0b done=%0b valid=%0b want 0/0/0", in_ready, done, out_valid);
            end
        end
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL st_errcount got=%0d want=1", err_count); end
        in_valid = 1'b0;
        start_burst(10'h040, 16'd1);
        push(3'b000, 32'd7, 32'h0000_0013);
        total++; if (addr_out !== 10'h040 || instr_out !== 32'h0070_0013) begin
            bad++; $display("FAIL st_restart addr=%h instr=%h want 040/00700013", addr_out, instr_out);
        end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL st_done got=%0b want=1", done); end
        settle();
    endtask
`endif

    initial begin
        test_reset();
        test_itype();
        test_btype_stype();
        test_ju();
        test_burst_backpressure();
        test_len_zero();
        test_reset_midburst();
        test_start_in_run();
        test_back_to_back();
`ifdef IMM_ENCODE_STRICT_EN
        test_strict();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
